// File: rtl/addsub_sched.sv
// Two-requester add/sub scheduler that runs each W-bit operation serially through
// one shared 4-bit slice (one nibble per RUN cycle, LSB first) and returns it on a handshake.
module addsub_sched #(
   parameter int NIB = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [4*NIB-1:0] req0_a,
   input  logic [4*NIB-1:0] req0_b,
   input  logic             req0_m,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [4*NIB-1:0] req1_a,
   input  logic [4*NIB-1:0] req1_b,
   input  logic             req1_m,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [4*NIB-1:0] rsp_sum,
   output logic             rsp_cot,
   output logic             rsp_v,
   output logic             busy
);

   localparam int KW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state, state_nxt;
   logic [KW-1:0]       k;
   logic                last_id;
   logic                id_q, m_q, carry, cot_q, v_q;
   logic [NIB-1:0][3:0] a_q, b_q, sum_q;

   logic                grant1, acc0, acc1, accept;
   logic [3:0]          a_nib, b_nib, lo_sum, nib_sum;
   logic [1:0]          hi_sum;
   logic                c3, c4;

   // last_id names the requester granted most recently; on contention the other one wins.
   assign grant1 = req1_valid & (~req0_valid | ~last_id);
   assign acc0   = req0_valid & req0_ready;
   assign acc1   = req1_valid & req1_ready;
   assign accept = acc0 | acc1;

   // Shared slice, split at bit 3 so the carry into the MSB is visible for overflow.
   always_comb begin
      a_nib   = a_q[k];
      b_nib   = b_q[k] ^ {4{m_q}};
      lo_sum  = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry};
      c3      = lo_sum[3];
      hi_sum  = {1'b0, a_nib[3]} + {1'b0, b_nib[3]} + {1'b0, c3};
      c4      = hi_sum[1];
      nib_sum = {hi_sum[0], lo_sum[2:0]};
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (k == K_LAST) state_nxt = DONE;
         DONE:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp_valid  = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: if (!rst) begin
            req0_ready = req0_valid & ~grant1;
            req1_ready = grant1;
         end
         DONE:    rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // NOTE: operand holding registers carry no reset; they are always loaded before use.
   always_ff @(posedge clk) begin
      if (state == IDLE && accept) begin
         a_q <= acc1 ? req1_a : req0_a;
         b_q <= acc1 ? req1_b : req0_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k       <= '0;
         last_id <= 1'b1;
         id_q    <= 1'b0;
         m_q     <= 1'b0;
         carry   <= 1'b0;
         sum_q   <= '0;
         cot_q   <= 1'b0;
         v_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               id_q    <= acc1;
               last_id <= acc1;
               m_q     <= acc1 ? req1_m : req0_m;
               carry   <= acc1 ? req1_m : req0_m;
               k       <= '0;
            end
            RUN: begin
               sum_q[k] <= nib_sum;
               carry    <= c4;
               k        <= k + KW'(1);
               if (k == K_LAST) begin
                  cot_q <= c4;
                  v_q   <= c3 ^ c4;
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_id  = id_q;
   assign rsp_sum = sum_q;
   assign rsp_cot = cot_q;
   assign rsp_v   = v_q;

endmodule

// File: tb/tb_addsub_sched.sv
// Randomized bench for addsub_sched (NIB = 4) against a word-level arithmetic and
// round-robin reference model.
module tb_addsub_sched;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req0_ready, req0_m;
   logic [W-1:0] req0_a, req0_b;
   logic         req1_valid, req1_ready, req1_m;
   logic [W-1:0] req1_a, req1_b;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_cot, rsp_v, busy;
   logic [W-1:0] rsp_sum;

   int n_checks = 0;
   int n_fail   = 0;
   bit last_id  = 1'b1;

   addsub_sched #(.NIB(NIB)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_m(req0_m),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_m(req1_m),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
      .rsp_cot(rsp_cot), .rsp_v(rsp_v), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Word-level reference: a + (b xor {W{m}}) + m, carry out and signed overflow.
   task automatic model(input logic [W-1:0] a, b, input logic m,
                        output logic [W-1:0] s, output logic c, output logic v);
      logic [W:0]   full;
      logic [W-1:0] bx;
      bx   = b ^ {W{m}};
      full = {1'b0, a} + {1'b0, bx} + (W+1)'(m);
      s    = full[W-1:0];
      c    = full[W];
      v    = (a[W-1] == bx[W-1]) && (s[W-1] != a[W-1]);
   endtask

   task automatic scramble();
      req0_a = W'($urandom); req0_b = W'($urandom); req0_m = 1'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom); req1_m = 1'($urandom);
   endtask

   // One request from a single requester, response held off for 'hold' DONE cycles.
   task automatic op(input bit id, input logic [W-1:0] a, b, input logic m, input int hold);
      logic [W-1:0] es;
      logic         ec, ev;
      int           n;
      model(a, b, m, es, ec, ev);
      scramble();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_m = m; end
      else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_m = m; end
      #1;
      check("ready_granted", id ? req1_ready : req0_ready, 1);
      check("ready_other", id ? req0_ready : req1_ready, 0);
      tick();
      last_id    = id;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      scramble();
      n = 0;
      while (!rsp_valid && n < 20) begin
         check("run_busy", busy, 1);
         tick();
         n++;
      end
      check("latency", n, NIB);
      check("rsp_sum", rsp_sum, es);
      check("rsp_cot", rsp_cot, ec);
      check("rsp_v", rsp_v, ev);
      check("rsp_id", rsp_id, id);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      rsp_ready  = 1'b0;
      #1;
      repeat (hold) begin
         check("done_readies", {req1_ready, req0_ready}, 0);
         tick();
         check("hold_valid", rsp_valid, 1);
         check("hold_busy", busy, 1);
         check("hold_sum", rsp_sum, es);
         check("hold_flags", {rsp_id, rsp_cot, rsp_v}, {id, ec, ev});
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("idle_busy", busy, 0);
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_grant", {req1_ready, req0_ready}, last_id ? 2'b01 : 2'b10);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   initial begin
      logic [W-1:0] es;
      logic         ec, ev;
      bit           g;
      int           n;

      rst = 1'b1; rsp_ready = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      scramble();
      tick();
      tick();
      check("rst_readies", {req1_ready, req0_ready}, 0);
      check("rst_outputs", {rsp_valid, rsp_id, rsp_cot, rsp_v, busy}, 0);
      check("rst_sum", rsp_sum, 0);
      rst = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();

      op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 3);
      op(1'b1, 16'h0005, 16'h0007, 1'b1, 0);
      op(1'b0, 16'h8000, 16'h0001, 1'b1, 1);
      op(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 0);
      op(1'b0, 16'h0000, 16'h0000, 1'b1, 2);

      for (int i = 0; i < 20; i++)
         op(1'($urandom), W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

      // Both requesters valid continuously: grants alternate, 6 cycles per operation.
      scramble();
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!(req0_ready | req1_ready) && n < 10) begin
            tick();
            n++;
         end
         check("alt_gap", n, 0);
         check("alt_one_ready", req0_ready & req1_ready, 0);
         g = ~last_id;
         check("alt_grant", req1_ready, g);
         if (g) model(req1_a, req1_b, req1_m, es, ec, ev);
         else   model(req0_a, req0_b, req0_m, es, ec, ev);
         tick();
         last_id = g;
         if (g) begin req1_a = W'($urandom); req1_b = W'($urandom); req1_m = 1'($urandom); end
         else   begin req0_a = W'($urandom); req0_b = W'($urandom); req0_m = 1'($urandom); end
         repeat (NIB) tick();
         check("alt_valid", rsp_valid, 1);
         check("alt_id", rsp_id, g);
         check("alt_sum", rsp_sum, es);
         check("alt_flags", {rsp_cot, rsp_v}, {ec, ev});
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      tick();

      // Abort in the second RUN cycle; req0 preference must come back with reset.
      req0_valid = 1'b1; req0_a = W'($urandom); req0_b = W'($urandom); req0_m = 1'($urandom);
      #1;
      check("abort_ready", req0_ready, 1);
      tick();
      last_id = 1'b0;
      req0_valid = 1'b0;
      tick();
      rst = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check("abort_rst_readies", {req1_ready, req0_ready}, 0);
      tick();
      check("abort_outputs", {rsp_valid, rsp_id, rsp_cot, rsp_v, busy, req1_ready, req0_ready}, 0);
      check("abort_sum", rsp_sum, 0);
      rst = 1'b0;
      last_id = 1'b1;
      #1;
      check("abort_pref_req0", {req1_ready, req0_ready}, 2'b01);
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("abort_no_rsp", {rsp_valid, busy}, 0);
      end

      op(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
